// File: rtl/vector_load_unit.sv
//------------------------------------------------------------------------------
// vector_load_unit
//
// Unit-stride vector load engine that sits behind vector_decoder. A start pulse
// latches the operands. The unit then fetches ceil((vl << vsew) / 4)
// consecutive 32-bit words over an OBI-style req/gnt/rvalid port. Each returned
// word is written into the next vector register, starting at vd_addr. A
// one-cycle done pulse (with err) reports completion back to the decoder.
//
// Ports:
//   clk, n_reset              clock, asynchronous active-low reset
//   start                     launch pulse; operands sampled in the same cycle
//   base_addr, vd_addr        byte address of element 0, first destination vreg
//   vl, vsew                  vector length (clamped to 16), element width code
//   busy, done, err           status; err is only meaningful while done is high
//   data_req_o / data_addr_o  memory request and word-aligned address
//   data_gnt_i                memory grant
//   data_rvalid_i, data_rdata_i, data_err_i
//                             in-order memory responses
//   vreg_we, vreg_waddr, vreg_wdata, vreg_wbe
//                             registered vector register write port
//------------------------------------------------------------------------------
module vector_load_unit #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int VREG_ADDR_W     = 5
) (
   input  logic                   clk,
   input  logic                   n_reset,
   input  logic                   start,
   input  logic [31:0]            base_addr,
   input  logic [VREG_ADDR_W-1:0] vd_addr,
   input  logic [4:0]             vl,
   input  logic [1:0]             vsew,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic                   data_req_o,
   output logic [31:0]            data_addr_o,
   input  logic                   data_gnt_i,
   input  logic                   data_rvalid_i,
   input  logic [31:0]            data_rdata_i,
   input  logic                   data_err_i,
   output logic                   vreg_we,
   output logic [VREG_ADDR_W-1:0] vreg_waddr,
   output logic [31:0]            vreg_wdata,
   output logic [3:0]             vreg_wbe
);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_t;

   state_t                 state;
   state_t                 state_next;

   logic [31:0]            base;
   logic [VREG_ADDR_W-1:0] vd;
   logic [4:0]             nwords;
   logic [3:0]             last_be;
   logic [4:0]             issued;
   logic [4:0]             received;
   logic [2:0]             outstanding;
   logic                   err_flag;

   logic [4:0]             vl_c;
   logic [6:0]             nbytes;
   logic [4:0]             nwords_launch;
   logic [3:0]             last_be_launch;
   logic                   bad_launch;
   logic                   grant;
   logic                   accept;

   // Launch-time decode of the operands presented with start.
   always_comb begin
      vl_c          = (vl > 5'd16) ? 5'd16 : vl;
      nbytes        = 7'({2'b00, vl_c} << vsew);
      nwords_launch = 5'((nbytes + 7'd3) >> 2);
      bad_launch    = (base_addr[1:0] != 2'b00) || (vsew == 2'd3);
      case (nbytes[1:0])
         2'd1:    last_be_launch = 4'h1;
         2'd2:    last_be_launch = 4'h3;
         2'd3:    last_be_launch = 4'h7;
         default: last_be_launch = 4'hF;
      endcase
   end

   // A response is only accepted while a request is actually in flight, so
   // stale responses from before a reset, or stray rvalids, are ignored.
   assign grant  = data_req_o && data_gnt_i;
   assign accept = data_rvalid_i && (state == REQ || state == DRAIN) &&
                   (outstanding != 3'd0);

   assign busy        = (state != IDLE);
   assign done        = (state == FIN);
   assign err         = done && err_flag;
   assign data_req_o  = (state == REQ) && (issued < nwords) &&
                        (outstanding < 3'(MAX_OUTSTANDING));
   assign data_addr_o = data_req_o ? (base + {25'd0, issued, 2'b00}) : 32'd0;

   // State register.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DRAIN waits for received==nwords; by then the final
   // word's write is already on the registered write port.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (bad_launch || (nwords_launch == 5'd0)) begin
                  state_next = FIN;
               end else begin
                  state_next = REQ;
               end
            end
         end
         REQ: begin
            if (issued == nwords) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (received == nwords) begin
               state_next = FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand latches, request/response counters, sticky error and the
   // registered write port. Errored responses still count as received, but
   // they produce no write.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         base        <= 32'd0;
         vd          <= '0;
         nwords      <= 5'd0;
         last_be     <= 4'd0;
         issued      <= 5'd0;
         received    <= 5'd0;
         outstanding <= 3'd0;
         err_flag    <= 1'b0;
         vreg_we     <= 1'b0;
         vreg_waddr  <= '0;
         vreg_wdata  <= 32'd0;
         vreg_wbe    <= 4'd0;
      end else begin
         vreg_we <= 1'b0;
         if (state == IDLE && start) begin
            base        <= base_addr;
            vd          <= vd_addr;
            nwords      <= nwords_launch;
            last_be     <= last_be_launch;
            issued      <= 5'd0;
            received    <= 5'd0;
            outstanding <= 3'd0;
            err_flag    <= bad_launch;
         end else begin
            if (grant) begin
               issued <= issued + 5'd1;
            end
            case ({grant, accept})
               2'b10:   outstanding <= outstanding + 3'd1;
               2'b01:   outstanding <= outstanding - 3'd1;
               default: outstanding <= outstanding;
            endcase
            if (accept) begin
               received   <= received + 5'd1;
               vreg_we    <= !data_err_i;
               vreg_waddr <= vd + VREG_ADDR_W'(received);
               vreg_wdata <= data_rdata_i;
               vreg_wbe   <= (received == nwords - 5'd1) ? last_be : 4'hF;
               if (data_err_i) begin
                  err_flag <= 1'b1;
               end
            end
         end
      end
   end

endmodule
